f_npc_bpred: RTL

//  Fetch-stage next-PC unit with a direct-mapped branch target buffer (BTB) and 2-bit saturating counters.

---
 rtl/f_npc_bpred.sv | 127 ++++++++++++
 1 files changed

// File: rtl/f_npc_bpred.sv
// Fetch-stage next-PC unit: owns F_pc, predicts the next fetch PC from a direct-mapped
// BTB with 2-bit counters, and redirects fetch when the D stage resolves differently.
module f_npc_bpred #(
   parameter int          IDX_W       = 4,
   parameter logic [31:0] RESET_PC    = 32'h0000_3000,
   parameter logic [1:0]  CTR_INIT    = 2'b10,
   parameter bit          ENABLE_PRED = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   output logic [31:0] F_pc,
   input  logic        D_valid,
   input  logic [31:0] D_pc,
   input  logic        D_is_cti,
   input  logic        D_is_jump,
   input  logic        D_taken,
   input  logic [31:0] D_target,
   output logic        flush,
   output logic [31:0] mispred_cnt
);

   localparam int ENTRIES = 1 << IDX_W;
   localparam int TAG_W   = 32 - (IDX_W + 2);

   logic [31:0]        pc_q, pc_d;
   logic [31:0]        cnt_q, cnt_d;
   logic [ENTRIES-1:0] valid_q, valid_d;
   logic [ENTRIES-1:0] jmp_q, jmp_d;
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   logic [TAG_W-1:0]   tag_d    [ENTRIES];
   logic [29:0]        target_q [ENTRIES];
   logic [29:0]        target_d [ENTRIES];
   logic [1:0]         ctr_q    [ENTRIES];
   logic [1:0]         ctr_d    [ENTRIES];

   logic [IDX_W-1:0]   f_idx, d_idx;
   logic               f_hit, d_hit, pred_taken, res;
   logic [31:0]        pred_npc, act_npc;
   logic               unused_tgt_bits;

   assign unused_tgt_bits = ^D_target[1:0];

   function automatic logic [1:0] sat_inc(input logic [1:0] c);
      return (c == 2'b11) ? c : c + 2'd1;
   endfunction

   function automatic logic [1:0] sat_dec(input logic [1:0] c);
      return (c == 2'b00) ? c : c - 2'd1;
   endfunction

   always_comb begin
      f_idx      = pc_q[IDX_W+1:2];
      f_hit      = valid_q[f_idx] && (tag_q[f_idx] == pc_q[31:IDX_W+2]);
      pred_taken = ENABLE_PRED && f_hit && (jmp_q[f_idx] || ctr_q[f_idx][1]);
      pred_npc   = pred_taken ? {target_q[f_idx], 2'b00} : pc_q + 32'd4;
   end

   // F holds the instruction fetched right after D, so any disagreement with act_npc is a mispredict.
   always_comb begin
      res     = D_valid && !stall && !reset;
      act_npc = (D_is_cti && D_taken) ? D_target : D_pc + 32'd4;
      d_idx   = D_pc[IDX_W+1:2];
      d_hit   = valid_q[d_idx] && (tag_q[d_idx] == D_pc[31:IDX_W+2]);
   end

   assign flush = res && (act_npc != pc_q);

   always_comb begin
      valid_d  = valid_q;
      jmp_d    = jmp_q;
      tag_d    = tag_q;
      target_d = target_q;
      ctr_d    = ctr_q;
      if (res && D_is_cti) begin
         if (d_hit) begin
            if (D_taken) begin
               target_d[d_idx] = D_target[31:2];
               ctr_d[d_idx]    = sat_inc(ctr_q[d_idx]);
            end else begin
               ctr_d[d_idx] = jmp_q[d_idx] ? 2'b11 : sat_dec(ctr_q[d_idx]);
            end
         end else if (D_taken) begin
            valid_d[d_idx]  = 1'b1;
            tag_d[d_idx]    = D_pc[31:IDX_W+2];
            target_d[d_idx] = D_target[31:2];
            jmp_d[d_idx]    = D_is_jump;
            ctr_d[d_idx]    = D_is_jump ? 2'b11 : CTR_INIT;
         end
      end
   end

   always_comb begin
      pc_d  = pc_q;
      cnt_d = cnt_q;
      if (flush) begin
         pc_d  = act_npc;
         cnt_d = cnt_q + 32'd1;
      end else if (!stall) begin
         pc_d = pred_npc;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q    <= RESET_PC;
         cnt_q   <= '0;
         valid_q <= '0;
      end else begin
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
      end
   end

   // Payload fields are qualified by valid_q, so they need no reset.
   always_ff @(posedge clk) begin
      jmp_q    <= jmp_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
   end

   assign F_pc        = pc_q;
   assign mispred_cnt = cnt_q;

endmodule
